// File: rtl/demux_vc_if.sv
// Bus between the single-stream source and the two virtual-channel sinks of demux_vc.
// The master side is the upstream source plus the downstream sinks; the slave side is demux_vc.
interface demux_vc_if #(
    parameter int BITNUMBER = 5,
    parameter int DEPTH     = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                 valid_in;
    logic [BITNUMBER-1:0] data_in;
    logic                 pause_vc0;
    logic                 pause_vc1;
    logic                 ready_in;
    logic                 valid_out_vc0;
    logic [BITNUMBER-1:0] data_out_vc0;
    logic                 valid_out_vc1;
    logic [BITNUMBER-1:0] data_out_vc1;
    logic [CW-1:0]        count;
    logic                 drop;

    modport master (
        output valid_in, data_in, pause_vc0, pause_vc1,
        input  ready_in, valid_out_vc0, data_out_vc0, valid_out_vc1, data_out_vc1, count, drop
    );

    modport slave (
        input  valid_in, data_in, pause_vc0, pause_vc1,
        output ready_in, valid_out_vc0, data_out_vc0, valid_out_vc1, data_out_vc1, count, drop
    );
endinterface

// File: rtl/demux_vc.sv
// Receive-side VC splitter: buffers one word stream in a small FIFO and steers
// each head word to VC0 or VC1 by its routing bit, strictly in arrival order.
// A paused target blocks the whole queue; words arriving while full are dropped.
module demux_vc #(
    parameter int BITNUMBER = 5,
    parameter int DEPTH     = 4,
    parameter int ROUTE_BIT = BITNUMBER - 1
) (
    input  logic      clk,
    input  logic      reset,
    demux_vc_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef logic [BITNUMBER-1:0] word_t;

    word_t         mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          valid_vc0_q, valid_vc0_d;
    logic          valid_vc1_q, valid_vc1_d;
    word_t         data_vc0_q, data_vc0_d;
    word_t         data_vc1_q, data_vc1_d;
    logic          drop_q, drop_d;

    word_t head;
    logic  head_vc1;
    logic  full;
    logic  push;
    logic  pop;

    // Decode push/pop from the registered occupancy and the routing bit of the head word
    always_comb begin
        full     = (count_q == FULL);
        head     = mem_q[rd_ptr_q];
        head_vc1 = head[ROUTE_BIT];
        push     = bus.valid_in && !full;
        pop      = (count_q != '0) && !(head_vc1 ? bus.pause_vc1 : bus.pause_vc0);
    end

    // Next-state values for pointers, occupancy and the output registers
    always_comb begin
        // NOTE: every _d is assigned on every path (holds feed back from _q), so no latch can be inferred.
        wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d     = count_q + CW'(push) - CW'(pop);
        drop_d      = bus.valid_in && full;
        valid_vc0_d = pop && !head_vc1;
        valid_vc1_d = pop && head_vc1;
        data_vc0_d  = valid_vc0_d ? head : data_vc0_q;
        data_vc1_d  = valid_vc1_d ? head : data_vc1_q;
    end

    // Control and output registers, cleared immediately by reset
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            valid_vc0_q <= 1'b0;
            valid_vc1_q <= 1'b0;
            data_vc0_q  <= '0;
            data_vc1_q  <= '0;
            drop_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            valid_vc0_q <= valid_vc0_d;
            valid_vc1_q <= valid_vc1_d;
            data_vc0_q  <= data_vc0_d;
            data_vc1_q  <= data_vc1_d;
            drop_q      <= drop_d;
        end
    end

    // FIFO storage write port
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; reset empties the FIFO through the pointers and count, so stale words are never read.
        if (push) begin
            mem_q[wr_ptr_q] <= bus.data_in;
        end
    end

    assign bus.ready_in      = !full && !reset;
    assign bus.valid_out_vc0 = valid_vc0_q;
    assign bus.data_out_vc0  = data_vc0_q;
    assign bus.valid_out_vc1 = valid_vc1_q;
    assign bus.data_out_vc1  = data_vc1_q;
    assign bus.count         = count_q;
    assign bus.drop          = drop_q;
endmodule

// File: tb/tb_demux_vc.sv
// Self-checking bench for demux_vc: directed scenarios plus a randomized
// stream, all compared against a queue-based model of the splitter.
module tb_demux_vc;
    localparam int BITNUMBER = 5;
    localparam int DEPTH     = 4;
    localparam int CW        = $clog2(DEPTH) + 1;
    localparam int RB        = BITNUMBER - 1;
    localparam int VW        = 4 + CW + 2 * BITNUMBER;

    typedef logic [BITNUMBER-1:0] word_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    demux_vc_if #(.BITNUMBER(BITNUMBER), .DEPTH(DEPTH)) bus ();

    demux_vc #(.BITNUMBER(BITNUMBER), .DEPTH(DEPTH), .ROUTE_BIT(RB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: FIFO as a queue, plus the expected output registers.
    word_t fifo_m[$];
    logic  m_v0, m_v1, m_drop;
    word_t m_d0, m_d1;

    task automatic model_reset();
        fifo_m.delete();
        m_v0   = 1'b0;
        m_v1   = 1'b0;
        m_drop = 1'b0;
        m_d0   = '0;
        m_d1   = '0;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, settle past it.
    task automatic cycle(input logic v, input word_t d, input logic p0, input logic p1);
        word_t h;
        logic  was_full;
        bus.valid_in  = v;
        bus.data_in   = d;
        bus.pause_vc0 = p0;
        bus.pause_vc1 = p1;
        was_full = (fifo_m.size() == DEPTH);
        m_v0   = 1'b0;
        m_v1   = 1'b0;
        m_drop = v && was_full;
        if (fifo_m.size() > 0) begin
            h = fifo_m[0];
            if (!(h[RB] ? p1 : p0)) begin
                if (h[RB]) begin m_v1 = 1'b1; m_d1 = h; end
                else       begin m_v0 = 1'b1; m_d0 = h; end
                void'(fifo_m.pop_front());
            end
        end
        if (v && !was_full) fifo_m.push_back(d);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VW-1:0] snap_dut();
        return {bus.ready_in, bus.valid_out_vc0, bus.valid_out_vc1, bus.drop, bus.count,
                bus.data_out_vc0, bus.data_out_vc1};
    endfunction

    function automatic logic [VW-1:0] snap_model();
        return {(fifo_m.size() < DEPTH) && !reset, m_v0, m_v1, m_drop, CW'(fifo_m.size()), m_d0, m_d1};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        bus.valid_in = 1'b0; bus.data_in = '0; bus.pause_vc0 = 1'b0; bus.pause_vc1 = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (snap_dut() !== snap_model()) begin
            n_fail++; $display("FAIL reset_initial: got %h expected %h", snap_dut(), snap_model());
        end
        reset = 1'b0;
        cycle(1'b1, 5'h07, 1'b0, 1'b0);
        cycle(1'b1, 5'h19, 1'b0, 1'b0);
        cycle(1'b1, 5'h0A, 1'b1, 1'b1);
        cycle(1'b1, 5'h1B, 1'b1, 1'b1);
        n_checks++;
        if (bus.count !== CW'(3) || bus.data_out_vc0 !== 5'h07) begin
            n_fail++; $display("FAIL reset_prefill: got count=%0d d0=%h expected count=3 d0=07", bus.count, bus.data_out_vc0);
        end
        #2 reset = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (snap_dut() !== snap_model()) begin
            n_fail++; $display("FAIL reset_midstream: got %h expected %h", snap_dut(), snap_model());
        end
        @(posedge clk);
        #1 reset = 1'b0;
        cycle(1'b1, 5'h03, 1'b0, 1'b0);
        n_checks++;
        if (bus.count !== CW'(1) || bus.valid_out_vc0 !== 1'b0) begin
            n_fail++; $display("FAIL reset_first_push: got count=%0d v0=%b expected count=1 v0=0", bus.count, bus.valid_out_vc0);
        end
        cycle(1'b0, 5'h00, 1'b0, 1'b0);
        n_checks++;
        if ({bus.valid_out_vc0, bus.data_out_vc0, bus.valid_out_vc1} !== {1'b1, 5'h03, 1'b0}) begin
            n_fail++; $display("FAIL reset_first_word: got v0=%b d0=%h v1=%b expected v0=1 d0=03 v1=0",
                               bus.valid_out_vc0, bus.data_out_vc0, bus.valid_out_vc1);
        end
    endtask

    task automatic test_routing();
        word_t      w [4] = '{5'h01, 5'h12, 5'h05, 5'h1F};
        logic [5:0] exp_seq [4] = '{6'h01, 6'h32, 6'h05, 6'h3F};
        logic [5:0] obs[$];
        for (int i = 0; i < 6; i++) begin
            if (i < 4) cycle(1'b1, w[i], 1'b0, 1'b0);
            else       cycle(1'b0, 5'h00, 1'b0, 1'b0);
            n_checks++;
            if (snap_dut() !== snap_model()) begin
                n_fail++; $display("FAIL routing_state[%0d]: got %h expected %h", i, snap_dut(), snap_model());
            end
            n_checks++;
            if (bus.valid_out_vc0 && bus.valid_out_vc1) begin
                n_fail++; $display("FAIL routing_both_valid[%0d]: got 1 expected 0", i);
            end
            if (bus.valid_out_vc0) obs.push_back({1'b0, bus.data_out_vc0});
            if (bus.valid_out_vc1) obs.push_back({1'b1, bus.data_out_vc1});
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (obs.size() <= i || obs[i] !== exp_seq[i]) begin
                n_fail++; $display("FAIL routing_order[%0d]: got %h expected %h", i,
                                   (obs.size() > i) ? obs[i] : 6'h00, exp_seq[i]);
            end
        end
    endtask

    task automatic test_hol_blocking();
        cycle(1'b1, 5'h10, 1'b0, 1'b1);
        cycle(1'b1, 5'h02, 1'b0, 1'b1);
        n_checks++;
        if ({bus.valid_out_vc0, bus.valid_out_vc1, bus.count} !== {1'b0, 1'b0, CW'(2)}) begin
            n_fail++; $display("FAIL hol_blocked: got v0=%b v1=%b count=%0d expected v0=0 v1=0 count=2",
                               bus.valid_out_vc0, bus.valid_out_vc1, bus.count);
        end
        cycle(1'b0, 5'h00, 1'b0, 1'b0);
        n_checks++;
        if ({bus.valid_out_vc1, bus.data_out_vc1, bus.valid_out_vc0} !== {1'b1, 5'h10, 1'b0}) begin
            n_fail++; $display("FAIL hol_release_vc1: got v1=%b d1=%h v0=%b expected v1=1 d1=10 v0=0",
                               bus.valid_out_vc1, bus.data_out_vc1, bus.valid_out_vc0);
        end
        cycle(1'b0, 5'h00, 1'b0, 1'b0);
        n_checks++;
        if ({bus.valid_out_vc0, bus.data_out_vc0, bus.valid_out_vc1, bus.count} !== {1'b1, 5'h02, 1'b0, CW'(0)}) begin
            n_fail++; $display("FAIL hol_release_vc0: got v0=%b d0=%h v1=%b count=%0d expected v0=1 d0=02 v1=0 count=0",
                               bus.valid_out_vc0, bus.data_out_vc0, bus.valid_out_vc1, bus.count);
        end
    endtask

    task automatic test_overflow();
        word_t      w [5] = '{5'h01, 5'h13, 5'h05, 5'h17, 5'h09};
        logic [5:0] exp_seq [4] = '{6'h01, 6'h33, 6'h05, 6'h37};
        logic [5:0] obs[$];
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, w[i], 1'b1, 1'b1);
            if (i == 3) begin
                n_checks++;
                if ({bus.count, bus.ready_in, bus.drop} !== {CW'(4), 1'b0, 1'b0}) begin
                    n_fail++; $display("FAIL ovf_full: got count=%0d ready=%b drop=%b expected count=4 ready=0 drop=0",
                                       bus.count, bus.ready_in, bus.drop);
                end
            end
        end
        n_checks++;
        if ({bus.count, bus.drop} !== {CW'(4), 1'b1}) begin
            n_fail++; $display("FAIL ovf_drop: got count=%0d drop=%b expected count=4 drop=1", bus.count, bus.drop);
        end
        cycle(1'b0, 5'h00, 1'b1, 1'b1);
        n_checks++;
        if (bus.drop !== 1'b0) begin
            n_fail++; $display("FAIL ovf_drop_one_cycle: got drop=%b expected 0", bus.drop);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 5'h00, 1'b0, 1'b0);
            n_checks++;
            if (snap_dut() !== snap_model()) begin
                n_fail++; $display("FAIL ovf_drain_state[%0d]: got %h expected %h", i, snap_dut(), snap_model());
            end
            if (bus.valid_out_vc0) obs.push_back({1'b0, bus.data_out_vc0});
            if (bus.valid_out_vc1) obs.push_back({1'b1, bus.data_out_vc1});
        end
        n_checks++;
        if (obs.size() != 4 || obs[0] !== exp_seq[0] || obs[1] !== exp_seq[1] ||
            obs[2] !== exp_seq[2] || obs[3] !== exp_seq[3]) begin
            n_fail++; $display("FAIL ovf_order: got %0d words expected 4 in order 01,33,05,37", obs.size());
        end
    endtask

    task automatic test_push_pop_full();
        word_t      w [4] = '{5'h1E, 5'h06, 5'h1A, 5'h08};
        logic [5:0] exp_seq [3] = '{6'h06, 6'h3A, 6'h08};
        logic [5:0] obs[$];
        for (int i = 0; i < 4; i++) cycle(1'b1, w[i], 1'b1, 1'b1);
        cycle(1'b1, 5'h0F, 1'b0, 1'b0);
        n_checks++;
        if ({bus.valid_out_vc1, bus.data_out_vc1, bus.drop, bus.count} !== {1'b1, 5'h1E, 1'b1, CW'(3)}) begin
            n_fail++; $display("FAIL full_pushpop: got v1=%b d1=%h drop=%b count=%0d expected v1=1 d1=1e drop=1 count=3",
                               bus.valid_out_vc1, bus.data_out_vc1, bus.drop, bus.count);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 5'h00, 1'b0, 1'b0);
            if (bus.valid_out_vc0) obs.push_back({1'b0, bus.data_out_vc0});
            if (bus.valid_out_vc1) obs.push_back({1'b1, bus.data_out_vc1});
        end
        n_checks++;
        if (obs.size() != 3 || obs[0] !== exp_seq[0] || obs[1] !== exp_seq[1] ||
            obs[2] !== exp_seq[2] || bus.count !== CW'(0)) begin
            n_fail++; $display("FAIL full_drain: got %0d words count=%0d expected 3 words 06,3a,08 count=0",
                               obs.size(), bus.count);
        end
    endtask

    task automatic test_wraparound();
        word_t sent0[$], sent1[$], got0[$], got1[$];
        int    sent = 0;
        int    budget = 0;
        logic  v, p0, p1, last_pause;
        word_t w;
        last_pause = 1'b0;
        while ((sent < 12 || fifo_m.size() > 0) && budget < 300) begin
            v = (sent < 12) && (fifo_m.size() < DEPTH) && ($urandom_range(0, 3) != 0);
            w = {sent[0], 4'($urandom)};
            p0 = 1'b0;
            p1 = 1'b0;
            if (!last_pause && $urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 1) p0 = 1'b1;
                else                           p1 = 1'b1;
            end
            last_pause = p0 | p1;
            cycle(v, w, p0, p1);
            if (v) begin
                if (w[RB]) sent1.push_back(w);
                else       sent0.push_back(w);
                sent++;
            end
            n_checks++;
            if (snap_dut() !== snap_model()) begin
                n_fail++; $display("FAIL wrap_state[%0d]: got %h expected %h", budget, snap_dut(), snap_model());
            end
            n_checks++;
            if (bus.valid_out_vc0 && bus.valid_out_vc1) begin
                n_fail++; $display("FAIL wrap_both_valid[%0d]: got 1 expected 0", budget);
            end
            if (bus.valid_out_vc0) got0.push_back(bus.data_out_vc0);
            if (bus.valid_out_vc1) got1.push_back(bus.data_out_vc1);
            budget++;
        end
        n_checks++;
        if (budget >= 300) begin
            n_fail++; $display("FAIL wrap_timeout: got %0d cycles expected under 300", budget);
        end
        n_checks++;
        if (got0.size() != sent0.size()) begin
            n_fail++; $display("FAIL wrap_vc0_len: got %0d expected %0d", got0.size(), sent0.size());
        end else begin
            for (int i = 0; i < got0.size(); i++)
                if (got0[i] !== sent0[i]) begin
                    n_fail++; $display("FAIL wrap_vc0_word[%0d]: got %h expected %h", i, got0[i], sent0[i]);
                    break;
                end
        end
        n_checks++;
        if (got1.size() != sent1.size()) begin
            n_fail++; $display("FAIL wrap_vc1_len: got %0d expected %0d", got1.size(), sent1.size());
        end else begin
            for (int i = 0; i < got1.size(); i++)
                if (got1[i] !== sent1[i]) begin
                    n_fail++; $display("FAIL wrap_vc1_word[%0d]: got %h expected %h", i, got1[i], sent1[i]);
                    break;
                end
        end
        n_checks++;
        if (bus.count !== CW'(0)) begin
            n_fail++; $display("FAIL wrap_count_end: got %0d expected 0", bus.count);
        end
    endtask

    initial begin
        test_reset();
        test_routing();
        test_hol_blocking();
        test_overflow();
        test_push_pop_full();
        test_wraparound();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule
